// File: rtl/video_mode_switcher.sv
// video_mode_switcher: picks one of NUM_MODES renderers and drives their RGB,
// VRAM read address and blanking margins toward vga_gen / vram_24k.
// A new mode only takes effect on the vsync-middle line (h==0, v==SWITCH_LINE).
// The switch is followed by BLANK_FRAMES black frames. busy and switch_done
// report switch progress to the bus side.
// Mode m (1..NUM_MODES) uses slot m-1. Mode 0 means disabled.
// state_dbg exposes the FSM state so that checkers can bind to it.
module video_mode_switcher #(
  parameter int NUM_MODES    = 2,
  parameter int MODE_W       = 3,
  parameter int COLOR_BITS   = 2,
  parameter int ADDR_W       = 15,
  // Numeric default is 1024 visible + 1 front porch + 3/2 sync (1280x1024 timing)
  parameter int SWITCH_LINE  = 1026,
  parameter int BLANK_FRAMES = 2,
  parameter int RESET_MODE   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             locked,
  input  logic [MODE_W-1:0]                mode_req,
  input  logic [11:0]                      h_counter,
  input  logic [11:0]                      v_counter,
  input  logic [NUM_MODES*3*COLOR_BITS-1:0] mode_rgb_in,
  input  logic [NUM_MODES*ADDR_W-1:0]      mode_addr_in,
  input  logic [NUM_MODES*8-1:0]           mode_side_rm,
  input  logic [NUM_MODES*8-1:0]           mode_bottom_rm,
  output logic [3*COLOR_BITS-1:0]          rgb_out,
  output logic [ADDR_W-1:0]                vram_addr,
  output logic [NUM_MODES-1:0]             mode_en,
  output logic                             timing_en,
  output logic [7:0]                       side_rm,
  output logic [7:0]                       bottom_rm,
  output logic [MODE_W-1:0]                active_mode,
  output logic                             busy,
  output logic                             switch_done,
  output logic [1:0]                       state_dbg
);

  localparam int RGB_W = 3 * COLOR_BITS;
  localparam int CNT_W = (BLANK_FRAMES < 1) ? 1 : $clog2(BLANK_FRAMES + 1);
  localparam logic [MODE_W-1:0] RESET_MODE_EFF =
    (RESET_MODE >= 1 && RESET_MODE <= NUM_MODES) ? MODE_W'(RESET_MODE) : '0;
  localparam logic [CNT_W-1:0] BLANK_INIT = CNT_W'(BLANK_FRAMES);
  localparam logic [11:0]      SW_LINE    = 12'(SWITCH_LINE);

  localparam logic [1:0] ST_OFF     = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  localparam logic [1:0] ST_BLANK   = 2'd3;

  logic [1:0]             state;
  logic [CNT_W-1:0]       blank_cnt;
  logic [MODE_W-1:0]      req_eff;
  logic                   boundary;
  logic                   run;
  logic                   show_pix;
  logic [RGB_W-1:0]       slot_rgb;
  logic [ADDR_W-1:0]      slot_addr;
  logic [7:0]             slot_side;
  logic [7:0]             slot_bottom;
  logic [NUM_MODES-1:0]   slot_onehot;

  // Out-of-range requests behave like "disabled"; B is the single switch instant per frame
  always_comb begin
    req_eff  = (int'(mode_req) > NUM_MODES) ? '0 : mode_req;
    boundary = (h_counter == 12'd0) && (v_counter == SW_LINE);
  end

  // Slot mux for the current mode; everything stays 0 when the mode is 0
  always_comb begin
    slot_rgb    = '0;
    slot_addr   = '0;
    slot_side   = '0;
    slot_bottom = '0;
    slot_onehot = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (active_mode == MODE_W'(i + 1)) begin
        slot_rgb       = mode_rgb_in[i*RGB_W +: RGB_W];
        slot_addr      = mode_addr_in[i*ADDR_W +: ADDR_W];
        slot_side      = mode_side_rm[i*8 +: 8];
        slot_bottom    = mode_bottom_rm[i*8 +: 8];
        slot_onehot[i] = 1'b1;
      end
    end
  end

  // Output enables: nothing runs without DCM lock or in OFF
  always_comb begin
    run         = locked && (state != ST_OFF);
    show_pix    = locked && ((state == ST_ACTIVE) || (state == ST_PENDING));
    timing_en   = run;
    mode_en     = run ? slot_onehot : '0;
    vram_addr   = slot_addr;
    side_rm     = slot_side;
    bottom_rm   = slot_bottom;
    busy        = (state == ST_PENDING) || (state == ST_BLANK);
    state_dbg   = state;
  end

  // Mode FSM; frozen while the clock source is unlocked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= (RESET_MODE_EFF == '0) ? ST_OFF : ST_ACTIVE;
      active_mode <= RESET_MODE_EFF;
      blank_cnt   <= '0;
      switch_done <= 1'b0;
    end else begin
      switch_done <= 1'b0;
      if (locked) begin
        case (state)
          ST_OFF: begin
            // Leaving OFF does not wait for the boundary: timing is stopped anyway
            if (req_eff != '0) begin
              active_mode <= req_eff;
              if (BLANK_FRAMES == 0) begin
                state       <= ST_ACTIVE;
                switch_done <= 1'b1;
              end else begin
                state     <= ST_BLANK;
                blank_cnt <= BLANK_INIT;
              end
            end
          end
          ST_ACTIVE: begin
            if (req_eff != active_mode) state <= ST_PENDING;
          end
          ST_PENDING: begin
            if (req_eff == active_mode) begin
              state <= ST_ACTIVE;
            end else if (boundary) begin
              if (req_eff == '0) begin
                state       <= ST_OFF;
                active_mode <= '0;
              end else begin
                active_mode <= req_eff;
                if (BLANK_FRAMES == 0) begin
                  state       <= ST_ACTIVE;
                  switch_done <= 1'b1;
                end else begin
                  state     <= ST_BLANK;
                  blank_cnt <= BLANK_INIT;
                end
              end
            end
          end
          ST_BLANK: begin
            if (boundary) begin
              if (blank_cnt <= CNT_W'(1)) begin
                state       <= ST_ACTIVE;
                switch_done <= 1'b1;
                blank_cnt   <= '0;
              end else begin
                blank_cnt <= blank_cnt - CNT_W'(1);
              end
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

  // Registered pixel: black in OFF/BLANK or when unlocked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb_out <= '0;
    else     rgb_out <= show_pix ? slot_rgb : '0;
  end

endmodule

// File: tb/tb_video_mode_switcher.sv
// Directed bench for video_mode_switcher. The frame boundary is produced by
// driving h_counter/v_counter straight to the switch line for one cycle.
// rgb_out expectations go through a queue: a value is pushed when the pixel is
// driven and popped one clock later.
module tb_video_mode_switcher;

  localparam int NM  = 2;
  localparam int MW  = 3;
  localparam int CB  = 2;
  localparam int AW  = 15;
  localparam int SWL = 1026;
  localparam int BF  = 2;
  localparam int RW  = 3 * CB;

  logic              clk = 1'b0;
  logic              rst;
  logic              locked;
  logic [MW-1:0]     mode_req;
  logic [11:0]       h_counter;
  logic [11:0]       v_counter;
  logic [NM*RW-1:0]  mode_rgb_in;
  logic [NM*AW-1:0]  mode_addr_in;
  logic [NM*8-1:0]   mode_side_rm;
  logic [NM*8-1:0]   mode_bottom_rm;
  logic [RW-1:0]     rgb_out;
  logic [AW-1:0]     vram_addr;
  logic [NM-1:0]     mode_en;
  logic              timing_en;
  logic [7:0]        side_rm;
  logic [7:0]        bottom_rm;
  logic [MW-1:0]     active_mode;
  logic              busy;
  logic              switch_done;
  logic [1:0]        state_dbg;

  logic [RW-1:0]     exp_q[$];
  int                n_pass  = 0;
  int                n_total = 0;

  video_mode_switcher #(
    .NUM_MODES(NM), .MODE_W(MW), .COLOR_BITS(CB), .ADDR_W(AW),
    .SWITCH_LINE(SWL), .BLANK_FRAMES(BF), .RESET_MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .mode_req(mode_req),
    .h_counter(h_counter), .v_counter(v_counter),
    .mode_rgb_in(mode_rgb_in), .mode_addr_in(mode_addr_in),
    .mode_side_rm(mode_side_rm), .mode_bottom_rm(mode_bottom_rm),
    .rgb_out(rgb_out), .vram_addr(vram_addr), .mode_en(mode_en),
    .timing_en(timing_en), .side_rm(side_rm), .bottom_rm(bottom_rm),
    .active_mode(active_mode), .busy(busy), .switch_done(switch_done),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_slots();
    mode_rgb_in    = (NM*RW)'($urandom_range(0, (1 << (NM*RW)) - 1));
    mode_addr_in   = (NM*AW)'($urandom);
    mode_side_rm   = 16'($urandom_range(0, 65535));
    mode_bottom_rm = 16'($urandom_range(0, 65535));
  endtask

  // One clock: optional boundary, fresh slot data, and the rgb the DUT must show
  // for mode m (0 = black) one cycle later
  task automatic cyc(input bit bnd, input int m);
    logic [RW-1:0] e;
    h_counter = bnd ? 12'd0 : 12'd5;
    v_counter = bnd ? 12'(SWL) : 12'd100;
    randomize_slots();
    e = (m == 0) ? '0 : mode_rgb_in[(m-1)*RW +: RW];
    exp_q.push_back(e);
    tick();
    h_counter = 12'd5;
    v_counter = 12'd100;
    e = exp_q.pop_front();
    chk("rgb_out", 32'(rgb_out), 32'(e));
  endtask

  // Margins and address must come from slot m-1, or be 0 for mode 0
  task automatic chk_slot(input string tag, input int m);
    logic [AW-1:0] ea;
    logic [7:0]    es;
    logic [7:0]    eb;
    ea = (m == 0) ? '0 : mode_addr_in[(m-1)*AW +: AW];
    es = (m == 0) ? '0 : mode_side_rm[(m-1)*8 +: 8];
    eb = (m == 0) ? '0 : mode_bottom_rm[(m-1)*8 +: 8];
    chk({tag, ".vram_addr"}, 32'(vram_addr), 32'(ea));
    chk({tag, ".side_rm"},   32'(side_rm),   32'(es));
    chk({tag, ".bottom_rm"}, 32'(bottom_rm), 32'(eb));
  endtask

  initial begin
    rst = 1'b1; locked = 1'b1; mode_req = 3'd1;
    h_counter = 12'd5; v_counter = 12'd100;
    randomize_slots();
    tick(); tick();

    // Reset state
    chk("rst.active_mode", 32'(active_mode), 32'd1);
    chk("rst.rgb_out",     32'(rgb_out),     32'd0);
    chk("rst.switch_done", 32'(switch_done), 32'd0);
    chk("rst.busy",        32'(busy),        32'd0);
    rst = 1'b0;

    // 1: mode 1 runs, pixel follows slot 0 one clock late
    cyc(0, 1); cyc(0, 1); cyc(0, 1);
    chk("t1.mode_en",   32'(mode_en),   32'b01);
    chk("t1.timing_en", 32'(timing_en), 32'd1);
    chk_slot("t1", 1);

    // 2: request mode 2, it applies only at the boundary, then 2 black frames
    mode_req = 3'd2;
    cyc(0, 1);
    chk("t2.pend.busy",   32'(busy),        32'd1);
    chk("t2.pend.active", 32'(active_mode), 32'd1);
    chk("t2.pend.en",     32'(mode_en),     32'b01);
    cyc(0, 1);
    cyc(1, 1);
    chk("t2.blank.active", 32'(active_mode), 32'd2);
    chk("t2.blank.en",     32'(mode_en),     32'b10);
    chk("t2.blank.done",   32'(switch_done), 32'd0);
    chk_slot("t2.blank", 2);
    cyc(0, 0);
    cyc(1, 0);
    chk("t2.b1.done", 32'(switch_done), 32'd0);
    chk("t2.b1.busy", 32'(busy),        32'd1);
    cyc(0, 0);
    cyc(1, 0);
    chk("t2.b2.done", 32'(switch_done), 32'd1);
    chk("t2.b2.busy", 32'(busy),        32'd0);
    cyc(0, 2);
    chk("t2.pulse_len", 32'(switch_done), 32'd0);

    // 3: 2->1->2 before the boundary cancels the switch
    mode_req = 3'd1;
    cyc(0, 2);
    chk("t3.busy_pend", 32'(busy), 32'd1);
    mode_req = 3'd2;
    cyc(0, 2);
    chk("t3.busy_back", 32'(busy), 32'd0);
    cyc(1, 2);
    chk("t3.active", 32'(active_mode), 32'd2);
    chk("t3.done",   32'(switch_done), 32'd0);

    // 4: disable at the boundary, then re-enable without waiting for it
    mode_req = 3'd0;
    cyc(0, 2);
    cyc(1, 2);
    chk("t4.off.timing", 32'(timing_en),   32'd0);
    chk("t4.off.en",     32'(mode_en),     32'd0);
    chk("t4.off.active", 32'(active_mode), 32'd0);
    chk("t4.off.busy",   32'(busy),        32'd0);
    cyc(0, 0);
    mode_req = 3'd2;
    cyc(0, 0);
    chk("t4.on.active", 32'(active_mode), 32'd2);
    chk("t4.on.busy",   32'(busy),        32'd1);
    chk("t4.on.timing", 32'(timing_en),   32'd1);
    cyc(1, 0);
    cyc(1, 0);
    chk("t4.done", 32'(switch_done), 32'd1);
    cyc(0, 2);

    // 5: out-of-range request acts as disable
    mode_req = 3'd5;
    cyc(0, 2);
    chk("t5.pend.busy", 32'(busy), 32'd1);
    cyc(1, 2);
    chk("t5.off.timing", 32'(timing_en), 32'd0);
    chk_slot("t5.off", 0);
    cyc(0, 0);
    chk("t5.stay_off", 32'(active_mode), 32'd0);

    // 6: lose lock during BLANK: outputs dark, count frozen across boundaries
    mode_req = 3'd1;
    cyc(0, 0);
    chk("t6.blank.active", 32'(active_mode), 32'd1);
    locked = 1'b0;
    for (int f = 0; f < 3; f++) begin
      cyc(0, 0);
      cyc(1, 0);
    end
    chk("t6.unl.timing", 32'(timing_en),   32'd0);
    chk("t6.unl.en",     32'(mode_en),     32'd0);
    chk("t6.unl.busy",   32'(busy),        32'd1);
    chk("t6.unl.done",   32'(switch_done), 32'd0);
    locked = 1'b1;
    cyc(1, 0);
    chk("t6.relock1.done", 32'(switch_done), 32'd0);
    chk("t6.relock1.en",   32'(mode_en),     32'b01);
    cyc(1, 0);
    chk("t6.relock2.done", 32'(switch_done), 32'd1);
    cyc(0, 1);
    // Unlock while ACTIVE blacks the pixel but keeps the mode
    locked = 1'b0;
    cyc(0, 0);
    chk("t6.act_unl.en",     32'(mode_en),     32'd0);
    chk("t6.act_unl.active", 32'(active_mode), 32'd1);
    locked = 1'b1;
    cyc(0, 1);

    // Reset mid-switch returns to the reset mode
    mode_req = 3'd2;
    cyc(0, 1);
    chk("rst2.pend.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst2.busy",   32'(busy),        32'd0);
    chk("rst2.active", 32'(active_mode), 32'd1);
    chk("rst2.rgb",    32'(rgb_out),     32'd0);
    mode_req = 3'd1;
    tick();
    rst = 1'b0;
    cyc(0, 1);
    chk("rst2.after.busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
